verdict_collector: RTL and testbench
====================================

# verdict_collector

Downstream stage of the generated RTLola monitor (`topEntity`). It captures every cycle in which one or more monitor outputs are active (`output_i_aktv` high) as a snapshot `{tag, aktv mask, all output values}` and queues snapshots in a FIFO. It then serializes each snapshot onto a valid/ready stream, one beat per active output, for a host or trace sink. Overflow is recorded, never silent.

## Interface
- `DATA_W`, 64, width of each monitor output value (signed, passed through unmodified)
- `NUM_OUT`, 3, number of monitor output streams (1..255)
- `DEPTH`, 8, snapshot FIFO depth, power of two ≥ 2
- `CNT_W`, 16, width of drop counter
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  global enable; low freezes all state
- `out_data`  in  NUM_OUT*DATA_W  monitor outputs; slot i at `[i*DATA_W +: DATA_W]`
- `out_aktv`  in  NUM_OUT  per-output active flags
- `tag`  in  64  monitor event tag, sampled with the snapshot
- `clear`  in  1  synchronous clear of `overflow` and `drop_cnt`
- `m_valid`  out  1  beat available
- `m_ready`  in  1  consumer accepts beat
- `m_tag`  out  64  tag of current snapshot
- `m_index`  out  8  output stream index of the beat
- `m_value`  out  DATA_W  value of that output
- `m_last`  out  1  final beat of the snapshot
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy in snapshots (serializer register excluded)
- `overflow`  out  1  sticky: a snapshot was dropped
- `drop_cnt`  out  CNT_W  dropped snapshots, saturating

## Operation
- Capture: in a cycle with `en && |out_aktv`, write `{tag, out_aktv, out_data}` to the FIFO if `level < DEPTH` at cycle start. A serializer pop in the same cycle does not free space for that cycle's write. If full, drop the snapshot, set `overflow`, and increment `drop_cnt` (saturate at all-ones).
- Simultaneous write and pop on a non-full FIFO: both occur, `level` unchanged.
- Serializer FSM, two states:
  - IDLE: `m_valid=0`. If FIFO non-empty, pop the head into serializer registers (tag, remaining mask, data), then go to EMIT.
  - EMIT: `m_valid=1`.
    - `m_index` = lowest set bit of the remaining mask; `m_value` = that slot.
    - `m_last` = 1 when exactly one bit remains.
    - On `m_valid && m_ready`, clear that bit.
    - On the last beat: if FIFO non-empty, pop the next snapshot in the same cycle and stay in EMIT (no bubble). Otherwise go to IDLE.
- Stream rules:
  - `m_valid` never drops without a handshake.
  - `m_tag`, `m_index`, `m_value`, `m_last` are stable while `m_valid && !m_ready`.
  - Beats are ordered by snapshot, then by ascending index.
- `en=0`: no capture, no pop, `m_ready` ignored (no transfer). Outputs hold.
- `clear`: `overflow` and `drop_cnt` go to 0 at the next edge. If a drop occurs in the same cycle, the drop wins: `overflow=1`, `drop_cnt=1`.
- Reset (asynchronous, any state, including mid-snapshot): FIFO emptied, FSM goes to IDLE, and all outputs become 0 (`m_valid`, `m_tag`, `m_index`, `m_value`, `m_last`, `level`, `overflow`, `drop_cnt`). A partially emitted snapshot is discarded.

## Timing
- Capture-to-first-beat latency: `out_aktv` high in cycle N → written at end of N → popped at end of N+1 → `m_valid=1` in N+2 (empty FIFO, serializer idle).
- Throughput: one beat per cycle while `m_ready=1`. A snapshot with k active outputs occupies k cycles.
- `level` reflects writes/pops registered at the previous edge.
- All outputs registered; no combinational path from `m_ready` or `out_aktv` to any output.

## Test plan
- Single snapshot: `out_aktv=3'b101`, `tag=5`, out0=1, out2=7, `m_ready=1` → cycle N+2: beat (tag 5, idx 0, val 1, last 0); N+3: (5, 2, 7, last 1); then `m_valid=0`.
- Backpressure: as above with `m_ready=0` for 10 cycles → `m_valid=1` with idx 0/val 1 held constant. Release `m_ready` → both beats delivered in order, none duplicated.
- Overflow: `DEPTH=8`, `m_ready=0`, `out_aktv=3'b001` for 10 consecutive cycles → 9 accepted (1 in serializer, `level=8`), `drop_cnt=1`, `overflow=1`. Pulse `clear` → both 0. Then drain: 9 beats, tags in order.
- Back-to-back: `out_aktv=3'b111` every 3rd cycle, `m_ready=1` → `m_valid` continuously high after the first beat, indices 0,1,2,0,1,2…, `m_last` on every idx 2, no drops.
- Reset mid-emission: assert `rst` after the first beat of a 3-beat snapshot with 2 snapshots queued → `m_valid` and `level` go to 0 immediately. After release, no stale beats until a new capture.
- Enable gating: `out_aktv` pulses while `en=0` → no capture, `level` stays 0. With `en=0` during EMIT, `m_ready=1` causes no transfer.

Source files
------------

// File: rtl/verdict_collector.sv
// Captures active-output snapshots of the RTLola monitor into a FIFO and
// serializes each one as a valid/ready beat stream, one beat per active output.
module verdict_collector #(
   parameter int DATA_W  = 64,
   parameter int NUM_OUT = 3,
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NUM_OUT*DATA_W-1:0] out_data,
   input  logic [NUM_OUT-1:0]        out_aktv,
   input  logic [63:0]               tag,
   input  logic                      clear,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [63:0]               m_tag,
   output logic [7:0]                m_index,
   output logic [DATA_W-1:0]         m_value,
   output logic                      m_last,
   output logic [$clog2(DEPTH):0]    level,
   output logic                      overflow,
   output logic [CNT_W-1:0]          drop_cnt
);

   localparam int AW     = $clog2(DEPTH);
   localparam int SNAP_W = 64 + NUM_OUT + NUM_OUT*DATA_W;

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [SNAP_W-1:0]         r_mem [DEPTH];
   logic [AW-1:0]             r_wr_ptr;
   logic [AW-1:0]             r_rd_ptr;
   logic [AW:0]               r_level;
   logic [63:0]               r_tag;
   logic [NUM_OUT-1:0]        r_mask;
   logic [NUM_OUT*DATA_W-1:0] r_data;
   logic                      r_overflow;
   logic [CNT_W-1:0]          r_drop_cnt;

   logic                      w_full;
   logic                      w_empty;
   logic                      w_cap;
   logic                      w_wr;
   logic                      w_drop;
   logic                      w_fire;
   logic                      w_one;
   logic                      w_lastbeat;
   logic                      w_pop;
   logic [7:0]                w_idx;
   logic [NUM_OUT-1:0]        w_lowbit;
   logic [DATA_W-1:0]         w_val;

   // Fullness is judged on the level at cycle start, so a same-cycle pop never makes room.
   assign w_full     = (r_level == (AW+1)'(DEPTH));
   assign w_empty    = (r_level == '0);
   assign w_cap      = en && (|out_aktv);
   assign w_wr       = w_cap && !w_full;
   assign w_drop     = w_cap && w_full;
   assign w_fire     = en && (r_state == EMIT) && m_ready;
   assign w_one      = ($countones(r_mask) == 1);
   assign w_lastbeat = w_fire && w_one;
   assign w_pop      = en && !w_empty && ((r_state == IDLE) || w_lastbeat);

   always_comb begin
      w_idx    = '0;
      w_lowbit = '0;
      w_val    = r_data[DATA_W-1:0];
      for (int i = NUM_OUT-1; i >= 0; i--) begin
         if (r_mask[i]) begin
            w_idx       = 8'(i);
            w_lowbit    = '0;
            w_lowbit[i] = 1'b1;
            w_val       = r_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {tag, out_aktv, out_data};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_wr && !w_pop) begin
            r_level <= r_level + (AW+1)'(1);
         end else if (w_pop && !w_wr) begin
            r_level <= r_level - (AW+1)'(1);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_pop) w_state_next = EMIT;
         EMIT:    if (w_lastbeat && !w_pop) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_tag   <= '0;
         r_mask  <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_pop) begin
            {r_tag, r_mask, r_data} <= r_mem[r_rd_ptr];
         end else if (w_fire) begin
            r_mask <= r_mask & ~w_lowbit;
         end
      end
   end

   // A drop in the same cycle as clear wins, leaving a count of one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else if (en) begin
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear) begin
               r_drop_cnt <= CNT_W'(1);
            end else if (r_drop_cnt != '1) begin
               r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
         end else if (clear) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end
      end
   end

   assign m_valid  = (r_state == EMIT);
   assign m_tag    = r_tag;
   assign m_index  = w_idx;
   assign m_value  = w_val;
   assign m_last   = w_one;
   assign level    = r_level;
   assign overflow = r_overflow;
   assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_verdict_collector.sv
// Scoreboard bench for verdict_collector: expected beats are queued at capture
// time and compared as the stream hands them over.
module tb_verdict_collector;

   localparam int DATA_W  = 64;
   localparam int NUM_OUT = 3;
   localparam int DEPTH   = 8;
   localparam int CNT_W   = 16;

   typedef struct {
      logic [63:0] tag;
      logic [7:0]  idx;
      logic [63:0] val;
      logic        last;
   } beat_t;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      en;
   logic [NUM_OUT*DATA_W-1:0] out_data;
   logic [NUM_OUT-1:0]        out_aktv;
   logic [63:0]               tag;
   logic                      clear;
   logic                      m_valid;
   logic                      m_ready;
   logic [63:0]               m_tag;
   logic [7:0]                m_index;
   logic [DATA_W-1:0]         m_value;
   logic                      m_last;
   logic [$clog2(DEPTH):0]    level;
   logic                      overflow;
   logic [CNT_W-1:0]          drop_cnt;

   beat_t sbQ[$];
   int    compared   = 0;
   int    mismatched = 0;

   verdict_collector #(.DATA_W(DATA_W), .NUM_OUT(NUM_OUT), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .en(en), .out_data(out_data), .out_aktv(out_aktv),
      .tag(tag), .clear(clear), .m_valid(m_valid), .m_ready(m_ready),
      .m_tag(m_tag), .m_index(m_index), .m_value(m_value), .m_last(m_last),
      .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", name, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one capture cycle; when keep is set the snapshot's beats are queued.
   task automatic applyStimulus(input logic [63:0] t, input logic [2:0] aktv,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [63:0] d2, input bit keep);
      logic [63:0] vals [3];
      beat_t b;
      vals[0] = d0; vals[1] = d1; vals[2] = d2;
      tag      = t;
      out_aktv = aktv;
      out_data = {d2, d1, d0};
      if (keep && en) begin
         for (int i = 0; i < 3; i++) begin
            if (aktv[i]) begin
               b.tag  = t;
               b.idx  = 8'(i);
               b.val  = vals[i];
               b.last = ((aktv >> (i+1)) == 3'b000);
               sbQ.push_back(b);
            end
         end
      end
      tick();
      out_aktv = '0;
   endtask

   task automatic waitDrain(input string name);
      int n = 0;
      while ((sbQ.size() != 0 || m_valid) && n < 200) begin
         tick();
         n++;
      end
      checkOutput(name, {63'd0, (sbQ.size() == 0 && !m_valid)}, 64'd1);
   endtask

   always @(negedge clk) begin
      beat_t e;
      if (!rst && en && m_valid && m_ready) begin
         checkOutput("beat_expected", {63'd0, sbQ.size() == 0}, 64'd0);
         if (sbQ.size() != 0) begin
            e = sbQ.pop_front();
            checkOutput("beat_tag",   m_tag,           e.tag);
            checkOutput("beat_index", {56'd0, m_index}, {56'd0, e.idx});
            checkOutput("beat_value", m_value,         e.val);
            checkOutput("beat_last",  {63'd0, m_last}, {63'd0, e.last});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int gaps;
      bit seen;
      rst = 1'b1; en = 1'b1; out_data = '0; out_aktv = '0; tag = '0; clear = 1'b0; m_ready = 1'b0;
      tick(); tick();
      checkOutput("rst_valid",    {63'd0, m_valid},  64'd0);
      checkOutput("rst_level",    {60'd0, level},    64'd0);
      checkOutput("rst_overflow", {63'd0, overflow}, 64'd0);
      checkOutput("rst_drop",     {48'd0, drop_cnt}, 64'd0);
      checkOutput("rst_tag",      m_tag,             64'd0);
      checkOutput("rst_last",     {63'd0, m_last},   64'd0);
      rst = 1'b0;
      tick();

      // Single snapshot with latency check
      m_ready = 1'b1;
      applyStimulus(64'd5, 3'b101, 64'd1, 64'd0, 64'd7, 1'b1);
      checkOutput("single_n1_valid", {63'd0, m_valid}, 64'd0);
      checkOutput("single_n1_level", {60'd0, level},   64'd1);
      tick();
      checkOutput("single_n2_valid", {63'd0, m_valid}, 64'd1);
      checkOutput("single_n2_index", {56'd0, m_index}, 64'd0);
      tick();
      checkOutput("single_n3_index", {56'd0, m_index}, 64'd2);
      checkOutput("single_n3_last",  {63'd0, m_last},  64'd1);
      tick();
      checkOutput("single_done_valid", {63'd0, m_valid}, 64'd0);
      checkOutput("single_drained", 64'(sbQ.size()), 64'd0);

      // Backpressure hold
      m_ready = 1'b0;
      applyStimulus(64'd5, 3'b101, 64'd1, 64'd0, 64'd7, 1'b1);
      tick();
      for (int i = 0; i < 10; i++) begin
         checkOutput("bp_valid", {63'd0, m_valid}, 64'd1);
         checkOutput("bp_index", {56'd0, m_index}, 64'd0);
         checkOutput("bp_value", m_value,          64'd1);
         tick();
      end
      m_ready = 1'b1;
      waitDrain("bp_drain");

      // Overflow, clear and drain
      m_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(64'(100 + i), 3'b001, 64'(i * 3), 64'd0, 64'd0, i < 9);
      end
      checkOutput("ovf_level",    {60'd0, level},    64'd8);
      checkOutput("ovf_drop",     {48'd0, drop_cnt}, 64'd1);
      checkOutput("ovf_overflow", {63'd0, overflow}, 64'd1);
      checkOutput("ovf_valid",    {63'd0, m_valid},  64'd1);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("clr_drop",     {48'd0, drop_cnt}, 64'd0);
      checkOutput("clr_overflow", {63'd0, overflow}, 64'd0);
      m_ready = 1'b1;
      waitDrain("ovf_drain");

      // Back-to-back snapshots, no bubbles expected
      gaps = 0; seen = 1'b0;
      for (int c = 0; c < 24; c++) begin
         if (c % 3 == 0 && c < 15) begin
            applyStimulus(64'(300 + c), 3'b111, 64'(c), 64'(c + 1000), 64'(c + 2000), 1'b1);
         end else begin
            tick();
         end
         if (m_valid) seen = 1'b1;
         else if (seen && sbQ.size() != 0) gaps++;
      end
      checkOutput("b2b_gaps", 64'(gaps), 64'd0);
      checkOutput("b2b_drop", {48'd0, drop_cnt}, 64'd0);
      waitDrain("b2b_drain");

      // Enable gating
      en = 1'b0;
      applyStimulus(64'd400, 3'b011, 64'd9, 64'd9, 64'd9, 1'b0);
      checkOutput("en_level", {60'd0, level}, 64'd0);
      tick();
      checkOutput("en_valid_idle", {63'd0, m_valid}, 64'd0);
      en = 1'b1; m_ready = 1'b0;
      applyStimulus(64'd401, 3'b110, 64'd0, 64'd11, 64'd22, 1'b1);
      tick();
      en = 1'b0; m_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("en_hold_valid", {63'd0, m_valid}, 64'd1);
         checkOutput("en_hold_index", {56'd0, m_index}, 64'd1);
      end
      en = 1'b1;
      waitDrain("en_drain");

      // Reset mid-emission
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(64'(500 + i), 3'b111, 64'(i), 64'(i + 10), 64'(i + 20), 1'b1);
      end
      checkOutput("mid_level", {60'd0, level}, 64'd2);
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", {63'd0, m_valid}, 64'd0);
      checkOutput("mid_rst_level", {60'd0, level},   64'd0);
      checkOutput("mid_rst_tag",   m_tag,            64'd0);
      sbQ.delete();
      tick(); tick();
      rst = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checkOutput("post_rst_valid", {63'd0, m_valid}, 64'd0);
      end
      applyStimulus(64'd600, 3'b010, 64'd0, 64'd33, 64'd0, 1'b1);
      waitDrain("post_rst_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
